// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types for the pipeline trace buffer: capture FSM states
//               and bit positions of the packed hazard/control flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DRAIN   = 2'd3
    } trace_state_t;

    // Flag vector layout as packed by the integrator
    localparam int c_flag_depen        = 0;
    localparam int c_flag_a_depen_lo   = 1;
    localparam int c_flag_a_depen_hi   = 2;
    localparam int c_flag_b_depen_lo   = 3;
    localparam int c_flag_b_depen_hi   = 4;
    localparam int c_flag_exe_load     = 5;
    localparam int c_flag_btaken       = 6;
    localparam int c_flag_next_b_taken = 7;
    localparam int c_flag_pcsource_lo  = 8;
    localparam int c_flag_pcsource_hi  = 9;

endpackage
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : trace_ram
// Description : DEPTH x WIDTH register array, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 74
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_trace_buffer
// Description : Triggerable circular trace capture of {flags, inst, pc} with a
//               post-trigger window and oldest-first valid/ready readout.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FLAG_W    = 10,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       sample_en,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          inst,
    input  logic [FLAG_W-1:0]          flags,
    input  logic                       trig_en,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic [DATA_W-1:0]          trig_mask,
    input  logic                       ext_trig,
    output logic                       busy,
    output logic                       triggered,
    output logic                       done,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [2*DATA_W+FLAG_W-1:0] rd_data,
    output logic                       rd_last,
    output logic [$clog2(DEPTH)-1:0]   trig_pos,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                  c_addr_w   = $clog2(DEPTH);
    localparam int                  c_rec_w    = 2*DATA_W + FLAG_W;
    localparam logic [c_addr_w:0]   c_depth    = (c_addr_w+1)'(DEPTH);
    localparam logic [c_addr_w:0]   c_cnt_one  = (c_addr_w+1)'(1);
    localparam logic [c_addr_w-1:0] c_post_trg = c_addr_w'(POST_TRIG);
    localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);

    trace_state_t          r_state;
    trace_state_t          w_state_next;
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  r_triggered;
    logic [c_addr_w-1:0]   r_post_cnt;
    logic [c_addr_w-1:0]   r_trig_slot;
    logic [c_addr_w-1:0]   r_rd_idx;

    logic                  w_hit;
    logic                  w_wr_en;
    logic                  w_clear;
    logic                  w_pop;
    logic [c_addr_w-1:0]   w_oldest;
    logic [c_addr_w-1:0]   w_rd_ptr;
    logic [c_rec_w-1:0]    w_rdata;

    assign w_hit   = sample_en && (ext_trig ||
                     (trig_en && (((pc ^ trig_pc) & trig_mask) == '0)));
    assign w_wr_en = sample_en && (r_state == S_CAPTURE || r_state == S_POST);
    assign w_clear = arm && (r_state == S_IDLE || r_state == S_DRAIN);
    assign w_pop   = rd_valid && rd_ready;

    // DEPTH is a power of two, so count mod DEPTH is just its low bits
    assign w_oldest = r_wr_ptr - r_count[c_addr_w-1:0];
    assign w_rd_ptr = w_oldest + r_rd_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_hit) w_state_next = (POST_TRIG == 0) ? S_DRAIN : S_POST;
            end
            S_POST: begin
                if (sample_en && r_post_cnt == c_ptr_one) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // A re-arm discards the window even if a pop is offered
                if (arm)                  w_state_next = S_CAPTURE;
                else if (w_pop && rd_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
            r_post_cnt  <= '0;
            r_trig_slot <= '0;
            r_rd_idx    <= '0;
        end else if (w_clear) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
            r_post_cnt  <= '0;
            r_rd_idx    <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                if (r_count != c_depth) r_count <= r_count + c_cnt_one;
            end
            if (r_state == S_CAPTURE && w_hit) begin
                r_triggered <= 1'b1;
                r_trig_slot <= r_wr_ptr;
                r_post_cnt  <= c_post_trg;
            end
            if (r_state == S_POST && sample_en) begin
                r_post_cnt <= r_post_cnt - c_ptr_one;
            end
            if (w_pop) begin
                r_rd_idx <= r_rd_idx + c_ptr_one;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_rec_w)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata ({flags, inst, pc}),
        .i_raddr (w_rd_ptr),
        .o_rdata (w_rdata)
    );

    // A frozen window always holds the trigger sample, so DRAIN is never empty
    assign busy      = (r_state == S_CAPTURE) || (r_state == S_POST);
    assign done      = (r_state == S_DRAIN);
    assign triggered = r_triggered;
    assign count     = r_count;
    assign rd_valid  = (r_state == S_DRAIN);
    assign rd_last   = rd_valid && ({1'b0, r_rd_idx} == (r_count - c_cnt_one));
    assign rd_data   = rd_valid ? w_rdata : '0;
    assign trig_pos  = r_triggered ? (r_trig_slot - w_oldest) : '0;

endmodule
`default_nettype wire
